memory_unit: RTL

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit_if.sv | 34 +++
 rtl/memory_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/memory_unit_if.sv
// memory_unit_if: bus strobes, shared data bus and loader handshake
// master drives the i_* strobes/data, slave (memory_unit) drives the o_* status
interface memory_unit_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] i_bus;
   logic                  i_memory_address_in;
   logic                  i_ram_in;
   logic                  i_ram_out;
   logic [DATA_WIDTH-1:0] o_bus;
   logic                  o_bus_drive;
   logic                  i_load_mode;
   logic                  i_load_valid;
   logic [DATA_WIDTH-1:0] i_load_data;
   logic                  o_load_ready;
   logic                  o_load_done;
   logic [ADDR_WIDTH-1:0] o_address;
   logic                  o_parity_error;

   modport master (
      output i_bus, i_memory_address_in, i_ram_in, i_ram_out,
      output i_load_mode, i_load_valid, i_load_data,
      input  o_bus, o_bus_drive, o_load_ready, o_load_done,
      input  o_address, o_parity_error
   );

   modport slave (
      input  i_bus, i_memory_address_in, i_ram_in, i_ram_out,
      input  i_load_mode, i_load_valid, i_load_data,
      output o_bus, o_bus_drive, o_load_ready, o_load_done,
      output o_address, o_parity_error
   );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: MAR + RAM on a shared bus, with a program loader FSM
// ports: i_clock, i_reset_n (async low), m (memory_unit_if.slave); MEMORY_PARITY_EN adds parity
module memory_unit #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input logic        i_clock,
   input logic        i_reset_n,
   memory_unit_if.slave m
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] mar;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  idle;
   logic                  loading;
   logic                  enter_load;
   logic                  bus_we;
   logic                  load_we;
   logic                  we;
   logic                  drive;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  unused_bus;

   assign idle       = (state == S_IDLE);
   assign loading    = (state == S_LOAD);
   assign enter_load = idle & m.i_load_mode;
   assign bus_we     = idle & m.i_ram_in;
   assign load_we    = loading & m.i_load_valid;
   assign we         = bus_we | load_we;
   assign wr_addr    = bus_we ? mar : ptr;
   assign wr_data    = bus_we ? m.i_bus : m.i_load_data;
   // Reset gating keeps the bus released even while state is forced
   assign drive      = i_reset_n & idle & m.i_ram_out;
   assign unused_bus = ^m.i_bus;

   // RAM is deliberately not reset so a loaded program survives reset
   always_ff @(posedge i_clock) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
         mar   <= '0;
         ptr   <= '0;
      end else begin
         if (idle && m.i_memory_address_in)
            mar <= m.i_bus[ADDR_WIDTH-1:0];
         unique case (state)
            S_IDLE: begin
               if (m.i_load_mode) begin
                  state <= S_LOAD;
                  ptr   <= '0;
               end
            end
            S_LOAD: begin
               if (!m.i_load_mode) begin
                  state <= S_IDLE;
               end else if (m.i_load_valid) begin
                  // Pointer saturates at the last word instead of wrapping
                  if (ptr == LAST) state <= S_DONE;
                  else ptr <= ptr + 1'b1;
               end
            end
            S_DONE: begin
               if (!m.i_load_mode) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign m.o_bus        = drive ? mem[mar] : '0;
   assign m.o_bus_drive  = drive;
   assign m.o_load_ready = loading;
   assign m.o_load_done  = (state == S_DONE);
   assign m.o_address    = mar;

`ifdef MEMORY_PARITY_EN
   logic par_mem [DEPTH];
   logic perr;

   always_ff @(posedge i_clock) begin
      if (we) par_mem[wr_addr] <= ^wr_data;
   end

   // Sticky until reset or a fresh program load begins
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         perr <= 1'b0;
      end else if (enter_load) begin
         perr <= 1'b0;
      end else if (drive && ((^mem[mar]) != par_mem[mar])) begin
         perr <= 1'b1;
      end
   end

   assign m.o_parity_error = perr;
`else
   assign m.o_parity_error = 1'b0;
`endif
endmodule
